alu_seq: RTL and testbench

Parametrised multi-cycle successor to the 16-bit combinational ALU. It keeps the single-cycle ADD/SUB/AND/OR/ZERO/PASS operations and adds:
- iterative shifts (logical and arithmetic) and a shift-add multiply;
- registered result and flags;
- a start/busy/done handshake, so the processor control unit can stall on long operations.

It sits between the accumulator/operand registers and the writeback mux.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with iterative shifts and a shift-add multiply.
// Result and flags are registered and published together with a done pulse.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             greater,
    output logic             less
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    W_CNT = CW'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_PASS = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;
    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, hi, lo;
    logic [CW-1:0]    cnt;

    logic             accept, is_shift, multi;
    logic [CW-1:0]    k_in;
    logic [WIDTH:0]   sum_add, sum_sub, mul_sum;
    logic [WIDTH-1:0] sc_res, hi_nx, lo_nx;
    logic             sc_c, sc_v, step_out, fin_c;

    assign accept = start && (state != EXEC);

    // Shift amount saturates at WIDTH; the full B value is compared.
    always_comb begin
        is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        k_in     = (b >= W_LIM) ? W_CNT : b[CW-1:0];
        multi    = 1'b0;
        if (op == OP_MUL) begin
            multi = 1'b1;
            k_in  = W_CNT;
        end else if (is_shift) begin
            multi = (b != '0);
        end
    end

    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        case (op)
            OP_ADD: begin
                sc_res = sum_add[WIDTH-1:0];
                sc_c   = sum_add[WIDTH];
                sc_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sum_sub[WIDTH-1:0];
                sc_c   = sum_sub[WIDTH];
                sc_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:                 sc_res = a & b;
            OP_OR:                  sc_res = a | b;
            OP_SLL, OP_SRL, OP_SRA: sc_res = a;
            OP_PASS:                sc_res = b;
            default:                sc_res = '0;
        endcase
    end

    // One iteration step: a single-bit shift, or a multiply add-and-shift.
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
        hi_nx    = hi;
        lo_nx    = lo;
        step_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                lo_nx    = {lo[WIDTH-2:0], 1'b0};
                step_out = lo[WIDTH-1];
            end
            OP_SRL: begin
                lo_nx    = {1'b0, lo[WIDTH-1:1]};
                step_out = lo[0];
            end
            OP_SRA: begin
                lo_nx    = {lo[WIDTH-1], lo[WIDTH-1:1]};
                step_out = lo[0];
            end
            default: {hi_nx, lo_nx} = {mul_sum, lo[WIDTH-1:1]};
        endcase
        fin_c = (op_q == OP_MUL) ? (hi_nx != '0) : step_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: begin
                if (accept) state_nx = multi ? EXEC : FIN;
                else        state_nx = IDLE;
            end
            EXEC:    if (cnt == CW'(1)) state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == EXEC);
        done = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            greater  <= 1'b0;
            less     <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            cnt  <= k_in;
            hi   <= '0;
            lo   <= (op == OP_MUL) ? b : a;
            if (!multi) begin
                result   <= sc_res;
                zero     <= (sc_res == '0);
                carry    <= sc_c;
                overflow <= sc_v;
                greater  <= (a > b);
                less     <= (a < b);
            end
        end else if (state == EXEC) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                result   <= lo_nx;
                zero     <= (lo_nx == '0);
                carry    <= fin_c;
                overflow <= 1'b0;
                greater  <= (a_q > b_q);
                less     <= (a_q < b_q);
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed stimulus for alu_seq (WIDTH=16),
// checked every cycle against a behavioural model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, zero, carry, overflow, greater, less;
    logic [15:0] result;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result),
        .zero(zero), .carry(carry), .overflow(overflow),
        .greater(greater), .less(less)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] r;
        logic        c, v, g, l;
        logic [31:0] due;
    } exp_t;

    exp_t        q[$];
    logic [20:0] last;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;

    task automatic cmp(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o,
                                   input logic [15:0] x, y,
                                   input int now);
        exp_t e;
        int k, sx, sy, s;
        logic [31:0] p;
        logic signed [15:0] xs;
        e = '0;
        k = 0;
        sx = $signed(x);
        sy = $signed(y);
        xs = x;
        e.g = x > y;
        e.l = x < y;
        case (o)
            4'd0: begin
                p = x + y;
                e.r = p[15:0];
                e.c = p[16];
                s = sx + sy;
                e.v = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                e.r = x - y;
                e.c = x >= y;
                s = sx - sy;
                e.v = (s > 32767) || (s < -32768);
            end
            4'd2: e.r = x & y;
            4'd3: e.r = x | y;
            4'd4: begin
                k = (y > 16) ? 16 : int'(y);
                e.r = (k >= 16) ? 16'h0 : x << k;
                e.c = (k == 0) ? 1'b0 : x[16-k];
            end
            4'd5: begin
                k = (y > 16) ? 16 : int'(y);
                e.r = (k >= 16) ? 16'h0 : x >> k;
                e.c = (k == 0) ? 1'b0 : x[k-1];
            end
            4'd7: e.r = y;
            4'd8: begin
                p = x * y;
                e.r = p[15:0];
                e.c = p[31:16] != 0;
                k = 16;
            end
            4'd9: begin
                k = (y > 16) ? 16 : int'(y);
                e.r = (k >= 16) ? {16{x[15]}} : 16'(xs >>> k);
                e.c = (k == 0) ? 1'b0 : x[k-1];
            end
            default: e.r = 16'h0;
        endcase
        e.due = 32'(now + 1 + k);
        return e;
    endfunction

    // Every cycle: done/busy timing, flags on done, hold otherwise.
    task automatic monitor();
        exp_t e;
        logic [20:0] obs, want;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                last = '0;
            end else begin
                t++;
                obs = {result, zero, carry, overflow, greater, less};
                if (q.size() > 0 && q[0].due == 32'(t)) begin
                    e = q.pop_front();
                    want = {e.r, e.r == 16'h0, e.c, e.v, e.g, e.l};
                    cmp("done_ctl", {30'h0, done, busy}, 32'h2);
                    cmp("done_val", {11'h0, obs}, {11'h0, want});
                    last = want;
                end else begin
                    cmp("idle_ctl", {30'h0, done, busy},
                        {30'h0, 1'b0, q.size() > 0});
                    cmp("hold_val", {11'h0, obs}, {11'h0, last});
                end
                if (start && q.size() == 0)
                    q.push_back(model(op, a, b, t));
            end
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [15:0] x, y);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        cmp("rst_state", {busy, done, result, zero, carry, overflow,
                          greater, less}, 0);
        rst_n = 1'b1;

        drive(4'd0, 16'hFFFF, 16'h0001);
        wait_done(n);
        cmp("add_lat", n, 0);
        cmp("add_res", result, 16'h0000);
        cmp("add_flags", {zero, carry, overflow, greater, less}, 5'b11010);

        drive(4'd1, 16'h8000, 16'h0001);
        wait_done(n);
        cmp("sub_res", result, 16'h7FFF);
        cmp("sub_flags", {carry, overflow, less}, 3'b110);
        start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        start = 1'b0;
        cmp("b2b_done", done, 1);
        cmp("b2b_res", result, 16'h0003);

        drive(4'd4, 16'h0001, 16'd4);
        cmp("sll_busy", busy, 1);
        wait_done(n);
        cmp("sll_lat", n, 4);
        cmp("sll_res", {result, carry}, {16'h0010, 1'b0});

        drive(4'd9, 16'h8000, 16'd20);
        wait_done(n);
        cmp("sra_lat", n, 16);
        cmp("sra_res", result, 16'hFFFF);

        drive(4'd8, 16'h0100, 16'h0100);
        wait_done(n);
        cmp("mul_lat", n, 16);
        cmp("mul_res", {result, zero, carry}, {16'h0000, 2'b11});

        drive(4'd8, 16'h0003, 16'h0005);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1; op = 4'd0; a = 16'h0007; b = 16'h0007;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        cmp("mul_ign_lat", 4 + n, 16);
        cmp("mul_ign_res", {result, carry}, {16'h000F, 1'b0});
        repeat (3) @(posedge clk);

        drive(4'd8, 16'h0005, 16'h0003);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        cmp("rst_mid", {busy, done, result, zero, carry, overflow,
                        greater, less}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        drive(4'd0, 16'h1234, 16'h0001);
        wait_done(n);
        cmp("post_rst_add", result, 16'h1235);

        repeat (3000) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) != 0);
            op    = 4'($urandom_range(0, 15));
            a     = 16'($urandom);
            b     = $urandom_range(0, 1) ? 16'($urandom_range(0, 20))
                                         : 16'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
